// File: rtl/rng_arbiter_if.sv
// Requester-side bundle for rng_arbiter: level requests and reseed pulses in,
// one-hot grant pulses with the random byte out.
interface rng_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic             reseed;
    logic [N_REQ-1:0] gnt;
    logic             rand_valid;
    logic [7:0]       rand_out;

    modport master (
        output req,
        output reseed,
        input  gnt,
        input  rand_valid,
        input  rand_out
    );

    modport slave (
        input  req,
        input  reseed,
        output gnt,
        output rand_valid,
        output rand_out
    );
endinterface

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 8-bit LFSR between game requesters; owns the
// generator reseed line. Define RNG_ARB_GAP_EN to enforce GAP cycles between grants.
module rng_arbiter #(
    parameter int N_REQ = 4,
    parameter int GAP   = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    rng_arbiter_if.slave  bus,
    input  logic [7:0]    rand_in,
    output logic          seed_n
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("rng_arbiter: N_REQ must be in 2..8");
    end
    if (GAP < 2 || GAP > 255) begin : g_bad_gap
        $error("rng_arbiter: GAP must be in 2..255");
    end

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        IDLE  = 2'd1,
        GRANT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] ptr_next;
    logic             reseed_pending;
    logic [N_REQ-1:0] gnt_q;
    logic             valid_q;
    logic [7:0]       rand_q;

`ifdef RNG_ARB_GAP_EN
    // Counter preload so that HOLD lasts exactly GAP-2 cycles.
    localparam logic [7:0] HOLD_LOAD = (GAP > 2) ? 8'(GAP - 3) : 8'd0;
    logic [7:0] gap_cnt;
`endif

    // First set request at or after the pointer, wrapping from N_REQ-1 to 0.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [PTR_W-1:0] p
    );
        logic [PTR_W-1:0] found;
        int               k;
        found = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = int'(p) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (r[k]) begin
                found = PTR_W'(k);
            end
        end
        return found;
    endfunction

    always_comb begin
        pick     = rr_pick(bus.req, ptr);
        ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    assign bus.gnt        = gnt_q;
    assign bus.rand_valid = valid_q;
    assign bus.rand_out   = rand_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= SEED;
            seed_n         <= 1'b0;
            gnt_q          <= '0;
            valid_q        <= 1'b0;
            rand_q         <= 8'd0;
            ptr            <= '0;
            grant_idx      <= '0;
            reseed_pending <= 1'b0;
`ifdef RNG_ARB_GAP_EN
            gap_cnt        <= 8'd0;
`endif
        end else begin
            case (state)
                SEED: begin
                    seed_n <= 1'b1;
                    state  <= IDLE;
                end

                // Reseed wins over requests so the new seed lands before any delivery.
                IDLE: begin
                    if (reseed_pending || bus.reseed) begin
                        reseed_pending <= 1'b0;
                        seed_n         <= 1'b0;
                        state          <= SEED;
                    end else if (|bus.req) begin
                        rand_q    <= rand_in;
                        grant_idx <= pick;
                        gnt_q     <= N_REQ'(1) << pick;
                        valid_q   <= 1'b1;
                        state     <= GRANT;
                    end
                end

                GRANT: begin
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    ptr     <= ptr_next;
                    if (bus.reseed) begin
                        reseed_pending <= 1'b1;
                    end
`ifdef RNG_ARB_GAP_EN
                    if (GAP > 2) begin
                        gap_cnt <= HOLD_LOAD;
                        state   <= HOLD;
                    end else begin
                        state   <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end

                HOLD: begin
                    if (bus.reseed) begin
                        reseed_pending <= 1'b1;
                    end
`ifdef RNG_ARB_GAP_EN
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
`else
                    state <= IDLE;
`endif
                end

                default: begin
                    state <= SEED;
                end
            endcase
        end
    end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares the single 8-bit LFSR random generator between several game-logic requesters (ghost direction choosers, fruit spawner) so that no two consumers receive correlated, shifted copies of the same byte. It owns the generator's seed-load input, reseeding it once after reset and on demand. Grants are round-robin and spaced by a configurable number of cycles so the LFSR fully turns over between deliveries. Sits between the `random_generator` instance and the game FSMs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP`, 8: minimum clock cycles between successive `gnt` pulses, 2..255.

Ports:
- `clock`  in  1: system clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `req`  in  N_REQ: level request per requester; held high until its `gnt` bit is seen.
- `reseed`  in  1: single-cycle pulse requesting a generator reseed.
- `rand_in`  in  8: generator `q` output.
- `seed_n`  out  1: drives generator `reset_n`; low = load seed from generator counter.
- `gnt`  out  N_REQ: one-hot, single-cycle grant pulse.
- `rand_valid`  out  1: high in the same cycle as any `gnt` bit.
- `rand_out`  out  8: random byte for the granted requester; valid only while `rand_valid` is high.

## Operation
- States: SEED, IDLE, GRANT, HOLD.
- Reset values: state=SEED, `seed_n`=0, `gnt`=0, `rand_valid`=0, `rand_out`=0, rr pointer=0, gap counter=0, reseed_pending=0.
- SEED: drives `seed_n`=0 for exactly one cycle, then goes to IDLE. `seed_n` is registered and is 1 in every other state.
- IDLE:
  - If reseed_pending is set or `reseed` is high: go to SEED and clear pending. Reseed has priority over `req`.
  - Else if any `req` bit is high: select the first set bit at or after the pointer, searching upward with wrap from N_REQ-1 to 0. Register `rand_out`<=`rand_in` and the one-hot select, then go to GRANT.
  - Else: stay in IDLE.
- GRANT, one cycle:
  - `gnt`=the registered one-hot select and `rand_valid`=1.
  - Pointer <= granted index+1, wrapping to 0 past N_REQ-1.
  - Next state is HOLD if GAP>2, otherwise IDLE.
- HOLD: gap counter runs GAP-2 cycles, then goes to IDLE. `gnt` and `rand_valid` are 0.
- A `reseed` pulse seen in GRANT or HOLD sets reseed_pending and is serviced on the next IDLE. A pulse seen in SEED is dropped.
- A `req` bit that drops before being sampled in IDLE is not granted. Requests are never queued.
- `reset_n` low mid-operation returns every register to its reset value on the next edge. Any in-flight grant is lost.

## Timing
- Reset released at edge E0: SEED during cycle 0 (`seed_n`=0), IDLE during cycle 1, earliest `gnt` during cycle 2.
- Request latency: `req` sampled in IDLE at edge T gives `gnt`/`rand_valid` high during cycle T+1. `rand_out` equals `rand_in` as sampled at edge T.
- Grant spacing: with `RNG_ARB_GAP_EN` defined, rising edges of `gnt` are at least GAP cycles apart when requests are continuous.
- Reseed path: `reseed` seen in IDLE at edge T drives `seed_n` low during cycle T+1. The next grant is no earlier than cycle T+3.

## Configuration
- `RNG_ARB_GAP_EN` defined: HOLD state and gap counter are built, and GAP spacing is enforced.
- Not defined: HOLD and the counter are omitted, and GRANT always returns to IDLE. Grant spacing is then fixed at 2 cycles and the GAP parameter is ignored.

## Test plan
- Reset, then hold `req`=0: `seed_n` is low for exactly cycle 0 and high afterwards. `gnt`=0, `rand_out`=0.
- `req`=4'b1111 continuous, GAP=8, macro defined: `gnt` sequence is 0001, 0010, 0100, 1000, 0001, with pulses exactly 8 cycles apart. Each `rand_out` matches `rand_in` one cycle before its `gnt`.
- Same stimulus with the macro undefined: `gnt` pulses every 2 cycles, in the same rotation.
- Pointer at 2 with `req`=4'b0011: `gnt`=0001, then 0010, showing wrap-around.
- `reseed` pulse during HOLD: after HOLD ends, `seed_n` goes low for one cycle before any further `gnt`. The generator then reloads from its counter value.
- Assert `reset_n`=0 during the GRANT cycle: on the next cycle `gnt`=0, `rand_valid`=0 and pointer=0. After release, `seed_n` is low again for one cycle.
